// File: rtl/nodeio_nport.sv
// nodeio_nport: blocking rendezvous word send/receive over NUM_PORTS neighbour links.
// Define NODEIO_ANY_EN to enable ANY/LAST direction codes and the last_dir register.
//
//   state     | meaning
//   S_IDLE    | no transfer pending; tx/rx requests sampled (rx has priority)
//   S_TX_WAIT | word offered on latched link(s) until a neighbour acks or halt
//   S_RX_WAIT | waiting for a neighbour to offer on latched link(s), or halt
module nodeio_nport #(
    parameter  int NUM_PORTS = 4,
    parameter  int WORD_W    = 11,
    localparam int DIR_W     = $clog2(NUM_PORTS + 2),
    localparam int LW        = $clog2(NUM_PORTS)
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        tx,
    input  logic                        rx,
    input  logic [DIR_W-1:0]            direction,
    input  logic [WORD_W-1:0]           out_data,
    input  logic                        halt,
    output logic [WORD_W-1:0]           in_data,
    output logic                        tx_complete,
    output logic                        rx_complete,
    output logic                        busy,
    output logic [LW-1:0]               last_dir,
    output logic [NUM_PORTS-1:0]        p_out_valid,
    output logic [NUM_PORTS*WORD_W-1:0] p_out_data,
    input  logic [NUM_PORTS-1:0]        p_out_ack,
    input  logic [NUM_PORTS-1:0]        p_in_valid,
    input  logic [NUM_PORTS*WORD_W-1:0] p_in_data,
    output logic [NUM_PORTS-1:0]        p_in_ack
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_TX_WAIT = 2'd1, S_RX_WAIT = 2'd2} state_t;

    state_t                 state_q;
    logic [NUM_PORTS-1:0]   sel_q;
    logic [NUM_PORTS-1:0]   p_out_valid_q;
    logic [WORD_W-1:0]      data_q;
    logic [WORD_W-1:0]      in_data_q;
    logic                   tx_complete_q;
    logic                   rx_complete_q;

    logic [NUM_PORTS-1:0]   req_mask;
    logic                   req_nil;
    logic [NUM_PORTS-1:0]   tx_hit;
    logic [NUM_PORTS-1:0]   rx_hit;
    logic [NUM_PORTS-1:0]   rx_first;
    logic [WORD_W-1:0]      rx_word;

`ifdef NODEIO_ANY_EN
    localparam logic [DIR_W-1:0] DIR_ANY  = DIR_W'(NUM_PORTS);
    localparam logic [DIR_W-1:0] DIR_LAST = DIR_W'(NUM_PORTS + 1);

    logic                   any_q;
    logic                   last_valid_q;
    logic [LW-1:0]          last_dir_q;
    logic                   req_any;
    logic [NUM_PORTS-1:0]   tx_first;

    function automatic logic [LW-1:0] oh_idx(input logic [NUM_PORTS-1:0] oh);
        oh_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (oh[i]) oh_idx = oh_idx | LW'(i);
        end
    endfunction

    assign tx_first = tx_hit & (~tx_hit + 1'b1);
    assign last_dir = last_dir_q;
`else
    assign last_dir = '0;
`endif

    // Direction decode; an empty link mask means the request is NIL.
    always_comb begin
        req_mask = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (direction == DIR_W'(i)) req_mask[i] = 1'b1;
        end
`ifdef NODEIO_ANY_EN
        req_any = (direction == DIR_ANY);
        if (req_any) begin
            req_mask = '1;
        end else if (direction == DIR_LAST && last_valid_q) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (last_dir_q == LW'(i)) req_mask[i] = 1'b1;
            end
        end
`endif
    end

    assign req_nil  = (req_mask == '0);
    assign tx_hit   = p_out_ack & p_out_valid_q;
    assign rx_hit   = p_in_valid & sel_q;
    assign rx_first = rx_hit & (~rx_hit + 1'b1);

    always_comb begin
        rx_word = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (rx_first[i]) rx_word = p_in_data[i*WORD_W +: WORD_W];
        end
    end

    // Consume strobe is combinational so the neighbour sees it in the same cycle; halt wins.
    assign p_in_ack = (state_q == S_RX_WAIT && !halt) ? rx_first : '0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= S_IDLE;
            sel_q         <= '0;
            p_out_valid_q <= '0;
            data_q        <= '0;
            in_data_q     <= '0;
            tx_complete_q <= 1'b0;
            rx_complete_q <= 1'b0;
`ifdef NODEIO_ANY_EN
            any_q         <= 1'b0;
            last_valid_q  <= 1'b0;
            last_dir_q    <= '0;
`endif
        end else begin
            tx_complete_q <= 1'b0;
            rx_complete_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!halt && rx) begin
                        if (req_nil) begin
                            in_data_q     <= '0;
                            rx_complete_q <= 1'b1;
                        end else begin
                            sel_q   <= req_mask;
                            state_q <= S_RX_WAIT;
                        end
                    end else if (!halt && tx) begin
                        if (req_nil) begin
                            tx_complete_q <= 1'b1;
                        end else begin
                            data_q        <= out_data;
                            p_out_valid_q <= req_mask;
                            state_q       <= S_TX_WAIT;
                        end
                    end
`ifdef NODEIO_ANY_EN
                    any_q <= req_any;
`endif
                end
                S_TX_WAIT: begin
                    if (halt) begin
                        p_out_valid_q <= '0;
                        state_q       <= S_IDLE;
                    end else if (|tx_hit) begin
                        p_out_valid_q <= '0;
                        tx_complete_q <= 1'b1;
                        state_q       <= S_IDLE;
`ifdef NODEIO_ANY_EN
                        if (any_q) begin
                            last_dir_q   <= oh_idx(tx_first);
                            last_valid_q <= 1'b1;
                        end
`endif
                    end
                end
                S_RX_WAIT: begin
                    if (halt) begin
                        state_q <= S_IDLE;
                    end else if (|rx_hit) begin
                        in_data_q     <= rx_word;
                        rx_complete_q <= 1'b1;
                        state_q       <= S_IDLE;
`ifdef NODEIO_ANY_EN
                        if (any_q) begin
                            last_dir_q   <= oh_idx(rx_first);
                            last_valid_q <= 1'b1;
                        end
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_out
        assign p_out_data[g*WORD_W +: WORD_W] = p_out_valid_q[g] ? data_q : '0;
    end

    assign p_out_valid = p_out_valid_q;
    assign in_data     = in_data_q;
    assign tx_complete = tx_complete_q;
    assign rx_complete = rx_complete_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_nodeio_nport.sv
// Scoreboarded random bench for nodeio_nport; the bench plays all neighbour nodes.
module tb_nodeio_nport;
    localparam int NP = 4;
    localparam int W  = 11;
    localparam int DW = 3;
    localparam int LW = 2;
`ifdef NODEIO_ANY_EN
    localparam bit ANY_EN = 1'b1;
`else
    localparam bit ANY_EN = 1'b0;
`endif

    logic            CLK = 1'b0;
    logic            nRST;
    logic            tx, rx, halt;
    logic [DW-1:0]   direction;
    logic [W-1:0]    out_data;
    logic [W-1:0]    in_data;
    logic            tx_complete, rx_complete, busy;
    logic [LW-1:0]   last_dir;
    logic [NP-1:0]   p_out_valid, p_out_ack, p_in_valid, p_in_ack;
    logic [NP*W-1:0] p_out_data, p_in_data;

    nodeio_nport #(.NUM_PORTS(NP), .WORD_W(W)) dut (
        .CLK(CLK), .nRST(nRST), .tx(tx), .rx(rx), .direction(direction),
        .out_data(out_data), .halt(halt), .in_data(in_data),
        .tx_complete(tx_complete), .rx_complete(rx_complete), .busy(busy),
        .last_dir(last_dir), .p_out_valid(p_out_valid), .p_out_data(p_out_data),
        .p_out_ack(p_out_ack), .p_in_valid(p_in_valid), .p_in_data(p_in_data),
        .p_in_ack(p_in_ack)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        bit            is_rx;
        logic [W-1:0]  data;
        logic [LW-1:0] ld;
        int            cyc;
    } exp_t;
    exp_t sbq[$];

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: link remembered from the last ANY transfer.
    bit m_last_valid = 1'b0;
    int m_last       = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void resolve(input int dir, output logic [NP-1:0] tgt,
                                    output bit nil, output bit any);
        tgt = '0;
        nil = 1'b0;
        any = 1'b0;
        if (dir < NP) tgt[dir] = 1'b1;
        else if (ANY_EN && dir == NP) begin
            tgt = '1;
            any = 1'b1;
        end else if (ANY_EN && dir == NP + 1 && m_last_valid) tgt[m_last] = 1'b1;
        else nil = 1'b1;
    endfunction

    function automatic int lowest(input logic [NP-1:0] v);
        for (int i = 0; i < NP; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic void push(input bit is_rx, input logic [W-1:0] d);
        exp_t e;
        e.is_rx = is_rx;
        e.data  = d;
        e.ld    = LW'(m_last);
        e.cyc   = cyc;
        sbq.push_back(e);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every completion pulse must match the oldest expectation, in the expected cycle.
    always @(negedge CLK) begin
        exp_t e;
        if (nRST && (tx_complete || rx_complete)) begin
            if (sbq.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_complete: tx=%0d rx=%0d with nothing pending (t=%0t)",
                         tx_complete, rx_complete, $time);
            end else begin
                e = sbq.pop_front();
                chk("cpl_rx", rx_complete, e.is_rx);
                chk("cpl_tx", tx_complete, !e.is_rx);
                chk("cpl_cycle", cyc, e.cyc);
                if (e.is_rx) chk("in_data", in_data, e.data);
                chk("last_dir", last_dir, e.ld);
            end
        end
    end

    task automatic do_tx(input int dir, input logic [W-1:0] w, input int delay,
                         input bit use_halt, input bit halt_idle);
        logic [NP-1:0] tgt, ack;
        bit nil, any;
        resolve(dir, tgt, nil, any);
        ack = '0;
        tx = 1'b1; direction = DW'(dir); out_data = w; halt = halt_idle;
        tick();
        tx = 1'b0; halt = 1'b0; direction = DW'($urandom); out_data = W'($urandom);
        if (halt_idle || nil) begin
            if (!halt_idle) push(1'b0, '0);
            @(negedge CLK);
            chk("nil_valid", p_out_valid, 0);
            chk("nil_busy", busy, 0);
            tick();
            return;
        end
        for (int k = 0; k <= delay; k++) begin
            if (k < delay) p_out_ack = NP'($urandom) & ~tgt;
            else if (use_halt) begin
                halt = 1'b1;
                p_out_ack = NP'($urandom);
            end else begin
                ack = NP'($urandom) & tgt;
                if (ack == '0) ack = tgt;
                p_out_ack = ack | (NP'($urandom) & ~tgt);
            end
            @(negedge CLK);
            chk("tx_valid", p_out_valid, tgt);
            chk("tx_busy", busy, 1);
            for (int i = 0; i < NP; i++) if (tgt[i]) chk("tx_data", p_out_data[i*W +: W], w);
            tick();
        end
        p_out_ack = '0;
        halt = 1'b0;
        if (!use_halt) begin
            if (any) begin
                m_last = lowest(ack);
                m_last_valid = 1'b1;
            end
            push(1'b0, '0);
        end
        @(negedge CLK);
        chk("tx_drop", p_out_valid, 0);
        chk("tx_idle", busy, 0);
        tick();
    endtask

    task automatic do_rx(input int dir, input int delay, input bit use_halt, input bit also_tx,
                         input bit pre, input int fixed, input logic [NP-1:0] force_vld);
        logic [NP-1:0] tgt, vld, eack;
        logic [NP*W-1:0] dat;
        bit nil, any;
        int win;
        resolve(dir, tgt, nil, any);
        for (int i = 0; i < NP; i++) dat[i*W +: W] = (fixed >= 0) ? W'(fixed) : W'($urandom);
        if (force_vld != '0) vld = force_vld;
        else begin
            vld = NP'($urandom) & tgt;
            if (vld == '0) vld = tgt;
            if (!pre) vld = vld | (NP'($urandom) & ~tgt);
        end
        rx = 1'b1; tx = also_tx; direction = DW'(dir); out_data = W'($urandom);
        if (pre) begin
            p_in_valid = vld;
            p_in_data  = dat;
        end
        @(negedge CLK);
        chk("idle_no_ack", p_in_ack, 0);
        tick();
        rx = 1'b0; tx = 1'b0; direction = DW'($urandom);
        if (nil) begin
            push(1'b1, '0);
            p_in_valid = '0;
            @(negedge CLK);
            chk("nil_ack", p_in_ack, 0);
            chk("nil_busy", busy, 0);
            tick();
            return;
        end
        win = lowest(vld & tgt);
        for (int k = 0; k <= delay; k++) begin
            eack = '0;
            if (k < delay) begin
                p_in_valid = NP'($urandom) & ~tgt;
                p_in_data  = {NP{W'($urandom)}};
            end else if (use_halt) begin
                halt = 1'b1;
                p_in_valid = '0;
            end else begin
                p_in_valid = vld;
                p_in_data  = dat;
                eack[win]  = 1'b1;
            end
            @(negedge CLK);
            chk("rx_ack", p_in_ack, eack);
            chk("rx_busy", busy, 1);
            tick();
        end
        p_in_valid = '0;
        halt = 1'b0;
        if (!use_halt) begin
            if (any) begin
                m_last = win;
                m_last_valid = 1'b1;
            end
            push(1'b1, dat[win*W +: W]);
        end
        @(negedge CLK);
        chk("rx_idle", busy, 0);
        tick();
    endtask

    task automatic reset_mid_tx();
        tx = 1'b1; direction = '0; out_data = W'($urandom);
        tick();
        tx = 1'b0;
        @(negedge CLK);
        chk("pre_rst_valid", p_out_valid, 1);
        tick();
        nRST = 1'b0;
        #1;
        chk("rst_valid", p_out_valid, 0);
        chk("rst_data", p_out_data[W-1:0], 0);
        chk("rst_busy", busy, 0);
        chk("rst_last_dir", last_dir, 0);
        chk("rst_in_data", in_data, 0);
        m_last_valid = 1'b0;
        m_last = 0;
        sbq.delete();
        tick();
        nRST = 1'b1;
        tick();
    endtask

    initial begin
        nRST = 1'b0; tx = 1'b0; rx = 1'b0; halt = 1'b0; direction = '0; out_data = '0;
        p_out_ack = '0; p_in_valid = '0; p_in_data = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_cpl", {tx_complete, rx_complete}, 0);
        chk("reset_in_data", in_data, 0);
        chk("reset_valid", p_out_valid, 0);
        chk("reset_last_dir", last_dir, 0);
        nRST = 1'b1;
        tick();

        do_tx(1, 11'h07B, 2, 1'b0, 1'b0);
        do_rx(2, 0, 1'b0, 1'b0, 1'b1, 'h3E7, '0);
        do_rx(NP, 0, 1'b0, 1'b0, 1'b1, -1, 4'b1010);
        do_tx(NP + 1, W'($urandom), 1, 1'b0, 1'b0);
        do_rx(NP, 1, 1'b0, 1'b0, 1'b0, -1, 4'b0100);
        reset_mid_tx();
        do_rx(NP + 1, 0, 1'b0, 1'b0, 1'b0, -1, '0);
        do_rx(3, 1, 1'b0, 1'b1, 1'b0, -1, '0);
        do_tx(0, W'($urandom), 2, 1'b1, 1'b0);
        do_rx(3, 2, 1'b1, 1'b0, 1'b0, -1, '0);
        do_tx(2, W'($urandom), 0, 1'b0, 1'b1);
        do_tx(7, W'($urandom), 0, 1'b0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 1) == 0)
                do_tx($urandom_range(0, 7), W'($urandom), $urandom_range(0, 4),
                      $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
            else
                do_rx($urandom_range(0, 7), $urandom_range(0, 4), $urandom_range(0, 7) == 0,
                      $urandom_range(0, 3) == 0, 1'b0, -1, '0);
        end

        repeat (3) tick();
        chk("sb_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
